// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl: EX-stage stall/flush/bubble control, ALU forwarding selects and MAC sequencing.
// Define HAZ_PERF_EN to add the stall-cycle and flush performance counters.
module ex_hazard_ctrl #(
   parameter int MAC_LAT = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic [4:0]  ex_rs1,
   input  logic [4:0]  ex_rs2,
   input  logic [4:0]  ex_rd,
   input  logic        ex_memread,
   input  logic        ex_regwrite,
   input  logic        ex_mac,
   input  logic        ex_branch_taken,
   output logic        pc_stall,
   output logic        ifid_stall,
   output logic        idex_hold,
   output logic        idex_bubble,
   output logic        ifid_flush,
   output logic [1:0]  fwd_a,
   output logic [1:0]  fwd_b,
   output logic        mac_busy
`ifdef HAZ_PERF_EN
   ,
   output logic [31:0] perf_stall_cycles,
   output logic [31:0] perf_flushes
`endif
);
   typedef enum logic {IDLE, BUSY} state_t;
   state_t     state;
   logic [3:0] cnt;
   logic [4:0] mem_rd, wb_rd;
   logic       mem_rw, wb_rw;
   logic       busy, branch, mac_start, mac_stall, load_use;
   // rst_n gates the input-driven terms so every output is 0 while reset is held
   always_comb begin
      busy        = state == BUSY;
      branch      = rst_n && !busy && ex_branch_taken;
      mac_start   = rst_n && !busy && !ex_branch_taken && ex_mac && (MAC_LAT > 1);
      mac_stall   = mac_start || (busy && cnt != 4'd0);
      load_use    = rst_n && !busy && !ex_branch_taken && !mac_start && ex_memread &&
                    ex_rd != 5'd0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
      pc_stall    = mac_stall || load_use;
      ifid_stall  = mac_stall || load_use;
      idex_hold   = mac_stall;
      idex_bubble = branch || load_use;
      ifid_flush  = branch;
      mac_busy    = mac_start || busy;
      fwd_a       = (mem_rw && mem_rd != 5'd0 && mem_rd == ex_rs1) ? 2'b10 :
                    (wb_rw && wb_rd != 5'd0 && wb_rd == ex_rs1) ? 2'b01 : 2'b00;
      fwd_b       = (mem_rw && mem_rd != 5'd0 && mem_rd == ex_rs2) ? 2'b10 :
                    (wb_rw && wb_rd != 5'd0 && wb_rd == ex_rs2) ? 2'b01 : 2'b00;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= 4'd0;
         mem_rd <= 5'd0;
         wb_rd  <= 5'd0;
         mem_rw <= 1'b0;
         wb_rw  <= 1'b0;
      end else begin
         wb_rd  <= mem_rd;
         wb_rw  <= mem_rw;
         mem_rw <= idex_hold ? 1'b0 : ex_regwrite;
         mem_rd <= idex_hold ? mem_rd : ex_rd;
         state  <= mac_start ? BUSY : (busy && cnt == 4'd0) ? IDLE : state;
         cnt    <= mac_start ? 4'(MAC_LAT - 2) : (busy && cnt != 4'd0) ? cnt - 4'd1 : cnt;
      end
   end
`ifdef HAZ_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_stall_cycles <= 32'd0;
         perf_flushes      <= 32'd0;
      end else begin
         perf_stall_cycles <= perf_stall_cycles + {31'd0, pc_stall};
         perf_flushes      <= perf_flushes + {31'd0, ifid_flush};
      end
   end
`endif
endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// tb_ex_hazard_ctrl: directed checks of ex_hazard_ctrl with MAC_LAT=3.
module tb_ex_hazard_ctrl;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd;
   logic        ex_memread, ex_regwrite, ex_mac, ex_branch_taken;
   logic        pc_stall, ifid_stall, idex_hold, idex_bubble, ifid_flush, mac_busy;
   logic [1:0]  fwd_a, fwd_b;
   logic [5:0]  ctl;
   int          n_assert = 0;
   int          n_fail = 0;
   int          stalls;
`ifdef HAZ_PERF_EN
   logic [31:0] perf_stall_cycles, perf_flushes;
`endif

   always #5 clk = ~clk;

   ex_hazard_ctrl #(.MAC_LAT(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_memread(ex_memread), .ex_regwrite(ex_regwrite), .ex_mac(ex_mac),
      .ex_branch_taken(ex_branch_taken),
      .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_hold(idex_hold),
      .idex_bubble(idex_bubble), .ifid_flush(ifid_flush),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .mac_busy(mac_busy)
`ifdef HAZ_PERF_EN
      , .perf_stall_cycles(perf_stall_cycles), .perf_flushes(perf_flushes)
`endif
   );

   // {pc_stall, ifid_stall, idex_hold, idex_bubble, ifid_flush, mac_busy}
   assign ctl = {pc_stall, ifid_stall, idex_hold, idex_bubble, ifid_flush, mac_busy};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      id_rs1 = 0; id_rs2 = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0;
      ex_memread = 0; ex_regwrite = 0; ex_mac = 0; ex_branch_taken = 0;
   endtask

   // inputs are set at posedge+1, checked at posedge+2, then advance one cycle
   task automatic step(input string tag, input logic [5:0] exp);
      #1 chk(tag, {26'd0, ctl}, {26'd0, exp});
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clr();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      // reset: outputs forced low even with hazardous inputs present
      clr();
      rst_n = 1'b0;
      ex_branch_taken = 1; ex_memread = 1; ex_rd = 5; id_rs1 = 5; ex_mac = 1;
      #2 chk("rst_ctl", {26'd0, ctl}, 32'd0);
      chk("rst_fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
`ifdef HAZ_PERF_EN
      chk("rst_perf_stall", perf_stall_cycles, 32'd0);
      chk("rst_perf_flush", perf_flushes, 32'd0);
`endif
      do_reset();

      // load-use for exactly one cycle, then bubble clears it
      ex_memread = 1; ex_rd = 5; id_rs2 = 5; ex_regwrite = 1;
      step("lu_hit", 6'b110100);
      ex_memread = 0; ex_rd = 0; ex_regwrite = 0;
      step("lu_after", 6'b000000);
      ex_memread = 1; ex_rd = 0; id_rs2 = 0;
      step("lu_x0", 6'b000000);
      clr();

      // forwarding priority
      ex_rd = 7; ex_regwrite = 1;
      step("fw1", 6'b000000);
      ex_rs1 = 7; ex_rs2 = 5;
      #1 chk("fw2_a", {30'd0, fwd_a}, 32'd2);
      chk("fw2_b", {30'd0, fwd_b}, 32'd0);
      step("fw2", 6'b000000);
      ex_rs1 = 7; ex_rs2 = 7; ex_rd = 3;
      #1 chk("fw3_a_mem_over_wb", {30'd0, fwd_a}, 32'd2);
      chk("fw3_b_mem_over_wb", {30'd0, fwd_b}, 32'd2);
      step("fw3", 6'b000000);
      ex_rs2 = 3; ex_rd = 0;
      #1 chk("fw4_a_wb", {30'd0, fwd_a}, 32'd1);
      chk("fw4_b_mem", {30'd0, fwd_b}, 32'd2);
      step("fw4", 6'b000000);
      ex_rs1 = 0; ex_regwrite = 0;
      #1 chk("fw5_a_x0_mem", {30'd0, fwd_a}, 32'd0);
      chk("fw5_b_wb", {30'd0, fwd_b}, 32'd1);
      step("fw5", 6'b000000);
      #1 chk("fw6_a_x0_wb", {30'd0, fwd_a}, 32'd0);
      step("fw6", 6'b000000);
      clr();

      // single MAC: 2 stall cycles, 3 busy cycles, MEM bubbled while held
      ex_mac = 1; ex_rd = 9; ex_regwrite = 1; ex_rs1 = 9;
      step("mac1", 6'b111001);
      ex_branch_taken = 1;
      #1 chk("mac2_fwd_bubbled", {30'd0, fwd_a}, 32'd0);
      step("mac2_branch_ignored", 6'b111001);
      ex_branch_taken = 0;
      #1 chk("mac3_fwd_bubbled", {30'd0, fwd_a}, 32'd0);
      step("mac3", 6'b000001);
      ex_mac = 0; ex_rd = 0; ex_regwrite = 0;
      #1 chk("mac4_fwd_result", {30'd0, fwd_a}, 32'd2);
      step("mac4", 6'b000000);
      clr();

      // back-to-back MACs
      stalls = 0;
      ex_mac = 1;
      for (int i = 0; i < 6; i++) begin
         #1 stalls += int'(pc_stall);
         #0 step($sformatf("b2b_%0d", i), (i % 3 == 2) ? 6'b000001 : 6'b111001);
      end
      chk("b2b_stalls", stalls, 32'd4);
      ex_mac = 0;
      step("b2b_done", 6'b000000);

      // branch flush, and branch beating load-use
      ex_branch_taken = 1;
      step("br", 6'b000110);
      ex_memread = 1; ex_rd = 4; id_rs1 = 4;
      step("br_lu", 6'b000110);
      ex_branch_taken = 0;
      step("lu_no_br", 6'b110100);
      clr();
      step("br_done", 6'b000000);

      // reset in BUSY with cnt=1, then a full fresh MAC
      ex_mac = 1;
      step("rm1", 6'b111001);
      #1 chk("rm2", {26'd0, ctl}, 32'h39);
      rst_n = 1'b0;
      #1 chk("rm_async", {26'd0, ctl}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      step("rm_fresh1", 6'b111001);
      step("rm_fresh2", 6'b111001);
      step("rm_fresh3", 6'b000001);
      ex_mac = 0;
      step("rm_done", 6'b000000);

      // counter scenario from a clean reset: load-use, branch, MAC
      do_reset();
      ex_memread = 1; ex_rd = 6; id_rs1 = 6;
      step("p_lu", 6'b110100);
      clr();
      ex_branch_taken = 1;
      step("p_br", 6'b000110);
      clr();
      ex_mac = 1;
      step("p_mac1", 6'b111001);
      step("p_mac2", 6'b111001);
      step("p_mac3", 6'b000001);
      clr();
      step("p_idle", 6'b000000);
`ifdef HAZ_PERF_EN
      chk("perf_stall_cycles", perf_stall_cycles, 32'd3);
      chk("perf_flushes", perf_flushes, 32'd1);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
